// File: rtl/cache_ro_fill.sv
// Read-only, set-associative block cache with a single outstanding miss.
// A request is looked up one cycle after acceptance; a hit answers straight
// from the arrays, a miss fetches the block over the fill port and installs it
// in the chosen victim way. Flush invalidates every line and round-robin pointer.
module cache_ro_fill #(
    parameter int SIZE_BLOCK = 32,
    parameter int BIT_TOTAL  = 24,
    parameter int BIT_INDEX  = 8,
    parameter int WAY        = 2,
    parameter int BIT_CNT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [BIT_TOTAL-1:0]  i_req_addr,
    output logic                  o_rsp_valid,
    output logic [SIZE_BLOCK-1:0] o_rsp_data,
    input  logic                  i_flush,
    output logic                  o_mem_rd,
    output logic [BIT_TOTAL-1:0]  o_mem_addr,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_valid,
    input  logic [SIZE_BLOCK-1:0] i_mem_data,
    output logic [BIT_CNT-1:0]    o_hit_cnt,
    output logic [BIT_CNT-1:0]    o_miss_cnt
);

    localparam int SETS    = 1 << BIT_INDEX;
    localparam int BIT_TAG = BIT_TOTAL - BIT_INDEX;
    localparam int BIT_WAY = (WAY > 1) ? $clog2(WAY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT
    } state_t;

    state_t                state_q;
    logic [BIT_TOTAL-1:0]  reqAddr_q;
    logic                  flushPending_q;
    logic                  rspValid_q;
    logic [SIZE_BLOCK-1:0] rspData_q;
    logic                  memRd_q;
    logic [BIT_TOTAL-1:0]  memAddr_q;
    logic [BIT_CNT-1:0]    hitCnt_q;
    logic [BIT_CNT-1:0]    missCnt_q;

    logic [WAY-1:0]        valid_q     [SETS];
    logic [BIT_WAY-1:0]    rrPtr_q     [SETS];
    logic [BIT_TAG-1:0]    tagArray_q  [SETS][WAY];
    logic [SIZE_BLOCK-1:0] dataArray_q [SETS][WAY];

    logic [BIT_INDEX-1:0]  setIdx;
    logic [BIT_TAG-1:0]    reqTag;
    logic                  lookupHit;
    logic [SIZE_BLOCK-1:0] hitData;
    logic [BIT_WAY-1:0]    victimWay;
    logic [BIT_WAY-1:0]    rrPtr_d;
    logic                  fillEn;

    assign setIdx = reqAddr_q[BIT_INDEX-1:0];
    assign reqTag = reqAddr_q[BIT_TOTAL-1:BIT_INDEX];
    assign fillEn = (state_q == MEM_WAIT) && i_mem_valid;

    assign o_req_ready = (state_q == IDLE) && !flushPending_q && !i_flush;
    assign o_rsp_valid = rspValid_q;
    assign o_rsp_data  = rspData_q;
    assign o_mem_rd    = memRd_q;
    assign o_mem_addr  = memAddr_q;
    assign o_hit_cnt   = hitCnt_q;
    assign o_miss_cnt  = missCnt_q;

    // Tag compare across all ways of the latched set, victim choice (lowest invalid way, else the round-robin pointer) and the pointer's next value
    always_comb begin
        lookupHit = 1'b0;
        hitData   = '0;
        victimWay = rrPtr_q[setIdx];
        rrPtr_d   = '0;
        for (int w = 0; w < WAY; w++) begin
            if (valid_q[setIdx][w] && (tagArray_q[setIdx][w] == reqTag)) begin
                lookupHit = 1'b1;
                hitData   = dataArray_q[setIdx][w];
            end
        end
        for (int w = WAY - 1; w >= 0; w--) begin
            if (!valid_q[setIdx][w]) begin
                victimWay = BIT_WAY'(w);
            end
        end
        if (rrPtr_q[setIdx] != BIT_WAY'(WAY - 1)) begin
            rrPtr_d = rrPtr_q[setIdx] + 1'b1;
        end
    end

    // Tag and data storage carry no reset: a line is only ever read when its valid bit is set
    always_ff @(posedge i_clk) begin
        if (fillEn) begin
            tagArray_q[setIdx][victimWay]  <= reqTag;
            dataArray_q[setIdx][victimWay] <= i_mem_data;
        end
    end

    // Control FSM with registered response, fill-port outputs, valid bits, round-robin pointers and statistics
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            reqAddr_q      <= '0;
            flushPending_q <= 1'b0;
            rspValid_q     <= 1'b0;
            rspData_q      <= '0;
            memRd_q        <= 1'b0;
            memAddr_q      <= '0;
            hitCnt_q       <= '0;
            missCnt_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rrPtr_q[s] <= '0;
            end
        end else begin
            rspValid_q <= 1'b0;
            if ((state_q != IDLE) && i_flush) begin
                flushPending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (i_flush || flushPending_q) begin
                        flushPending_q <= 1'b0;
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            rrPtr_q[s] <= '0;
                        end
                    end else if (i_req_valid) begin
                        reqAddr_q <= i_req_addr;
                        state_q   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookupHit) begin
                        rspData_q  <= hitData;
                        rspValid_q <= 1'b1;
                        if (hitCnt_q != '1) begin
                            hitCnt_q <= hitCnt_q + 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        if (missCnt_q != '1) begin
                            missCnt_q <= missCnt_q + 1'b1;
                        end
                        memRd_q   <= 1'b1;
                        memAddr_q <= reqAddr_q;
                        state_q   <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (i_mem_ready) begin
                        memRd_q <= 1'b0;
                        state_q <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (fillEn) begin
                        valid_q[setIdx][victimWay] <= 1'b1;
                        rrPtr_q[setIdx]            <= rrPtr_d;
                        rspData_q                  <= i_mem_data;
                        rspValid_q                 <= 1'b1;
                        state_q                    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_ro_fill.md
CACHE_RO_FILL -- requirements
Module: cache_ro_fill

Interface
REQ-001 SHALL have parameter SIZE_BLOCK, default 32, block width in bits.
REQ-002 SHALL have parameter BIT_TOTAL, default 24, block address width.
REQ-003 SHALL have parameter BIT_INDEX, default 8, set index width; tag = addr[BIT_TOTAL-1:BIT_INDEX].
REQ-004 SHALL have parameter WAY, default 2, ways per set (power of two, >=1).
REQ-005 SHALL have parameter BIT_CNT, default 16, hit/miss counter width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port i_clk  in  1  clock, all state on rising edge.
REQ-008 SHALL have port i_rst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port i_req_valid  in  1  read request.
REQ-010 SHALL have port o_req_ready  out  1  request accepted when both high.
REQ-011 SHALL have port i_req_addr  in  BIT_TOTAL  block address.
REQ-012 SHALL have port o_rsp_valid  out  1  one-cycle response pulse.
REQ-013 SHALL have port o_rsp_data  out  SIZE_BLOCK  response data.
REQ-014 SHALL have port i_flush  in  1  invalidate all lines.
REQ-015 SHALL have ports o_mem_rd (out 1), o_mem_addr (out BIT_TOTAL), i_mem_ready (in 1), i_mem_valid (in 1), i_mem_data (in SIZE_BLOCK) forming the fill port.
REQ-016 SHALL have ports o_hit_cnt, o_miss_cnt  out  BIT_CNT  statistics.

Function
REQ-017 SHALL implement FSM states IDLE, LOOKUP, MEM_REQ, MEM_WAIT.
REQ-018 SHALL drive o_req_ready=1 only in IDLE with no flush pending and i_flush=0.
REQ-019 On acceptance SHALL latch i_req_addr and go to LOOKUP.
REQ-020 In LOOKUP, hit (matching tag and valid in any way) SHALL register the way's data to o_rsp_data, pulse o_rsp_valid the next cycle, increment o_hit_cnt, and return to IDLE; hit latency = 2 cycles from accept edge.
REQ-021 In LOOKUP, miss SHALL increment o_miss_cnt and go to MEM_REQ.
REQ-022 In MEM_REQ, o_mem_rd=1 and o_mem_addr=latched address SHALL be held stable until i_mem_ready=1, then go to MEM_WAIT.
REQ-023 i_mem_valid SHALL be ignored outside MEM_WAIT.
REQ-024 In MEM_WAIT on i_mem_valid SHALL write i_mem_data, tag and valid=1 into the victim way, register i_mem_data to o_rsp_data, pulse o_rsp_valid next cycle, return to IDLE.
REQ-025 Victim SHALL be lowest-index invalid way; if all valid, the set's round-robin pointer.
REQ-026 Per-set round-robin pointer SHALL advance by 1 mod WAY on every fill into that set; hits SHALL not change it.
REQ-027 o_rsp_data SHALL hold its last value when o_rsp_valid=0.
REQ-028 Counters SHALL saturate at all-ones and not wrap.
REQ-029 i_flush in IDLE SHALL clear all valid bits and round-robin pointers in one cycle, taking priority over a simultaneous request.
REQ-030 i_flush outside IDLE SHALL set a pending flag, applied on the first IDLE cycle before any new accept; the in-flight fill still completes and responds.
REQ-031 Flush SHALL not clear counters.

Reset
REQ-032 Reset low SHALL immediately force IDLE, all valid=0, round-robin=0, flush pending=0, o_rsp_valid=0, o_rsp_data=0, o_mem_rd=0, o_mem_addr=0, counters=0.
REQ-033 Reset mid-miss SHALL abandon the fill; late i_mem_valid after release SHALL be ignored.

Verification
REQ-034 Read 0x000010 on cold cache -> o_mem_rd with o_mem_addr=0x000010; return 0xDEADBEEF -> o_rsp_valid pulse, data 0xDEADBEEF, miss_cnt=1.
REQ-035 Re-read 0x000010 -> o_rsp_valid 2 cycles after accept, 0xDEADBEEF, no o_mem_rd, hit_cnt=1.
REQ-036 WAY=2: fill 0x000010, 0x000110, 0x000210 (same set) -> third fill evicts way 0 (0x000010); re-read 0x000010 misses, 0x000210 hits.
REQ-037 i_flush during MEM_WAIT -> fill response delivered, o_req_ready=0 for one IDLE cycle, then re-read of filled address misses.
REQ-038 Assert reset while o_mem_rd=1 -> o_mem_rd=0 asynchronously; i_mem_valid after release produces no o_rsp_valid.
REQ-039 BIT_CNT=4: 20 hits -> o_hit_cnt saturates at 0xF.
